icache_dm_refill: RTL and testbench
===================================

Name: icache_dm_refill

Overview:
- Parametrised direct-mapped instruction cache with multi-word lines and a blocking refill state machine.
- Sits between the fetch stage and instruction memory.
- Hits are answered combinationally in the same cycle. A miss performs a handshaked burst refill of one whole line.
- Adds a flush input and hit/miss statistics counters.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width. Must be 32; byte offset is fixed at 2 bits.
- NUM_LINES, 64, number of lines. Power of 2, at least 2.
- WORDS_PER_LINE, 4, words per line. Power of 2, at least 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_data  out  DATA_W  fetched word; 0 when cpu_ready=0.
- cpu_ready  out  1  cpu_data valid this cycle (hit).
- flush  in  1  invalidate all lines.
- mem_req  out  1  refill beat request.
- mem_addr  out  ADDR_W  word-aligned refill beat address.
- mem_ack  in  1  memory returns mem_data for the current beat this cycle.
- mem_data  in  DATA_W  refill data.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE), IDX = log2(NUM_LINES).
  - word select = addr[2+OFF-1:2]
  - index = addr[2+OFF+IDX-1:2+OFF]
  - tag = addr[ADDR_W-1:2+OFF+IDX]
- Reset (asserted low, async) sets:
  - all valid bits = 0
  - state = IDLE, beat counter = 0
  - mem_req = 0, mem_addr = 0
  - cpu_ready = 0, cpu_data = 0
  - both counters = 0, pending-flush = 0
  - Data and tag arrays are not reset.
- States: IDLE, REFILL.
- IDLE:
  - hit = cpu_req & valid[index] & (tag_array[index] == tag).
  - cpu_ready = hit, cpu_data = selected word; latency 0.
  - On a miss (cpu_req & !hit & !flush): latch line base address, beat = 0, go to REFILL. mem_req rises on the next cycle.
- REFILL:
  - cpu_ready = 0.
  - mem_req = 1; mem_addr = line base + 4*beat.
  - Each cycle with mem_ack: write mem_data to the word at beat of the latched index, then beat++.
  - mem_ack while beat = WORDS_PER_LINE-1: write the tag, set valid, clear mem_req on the same edge, return to IDLE. The retried fetch hits the following cycle.
  - mem_ack low: hold mem_req and mem_addr unchanged, with no timeout.
  - Changes to cpu_addr or cpu_req during REFILL are ignored; the refill always completes for the latched line.
- Miss penalty with single-cycle ack: 1 + WORDS_PER_LINE cycles until cpu_ready.
- flush:
  - In IDLE: all valid bits cleared at the next edge. cpu_ready in the flush cycle still reflects the pre-flush state. A miss in the same cycle is not started.
  - During REFILL: latched into pending-flush. Applied on the edge after the refill completes, which also invalidates the just-filled line.
- Counters:
  - hit_count +1 each cycle with cpu_ready = 1.
  - miss_count +1 on each IDLE->REFILL transition.
  - Both saturate at all-ones; flush does not clear them.
- Reset mid-REFILL: the refill is aborted, all lines are invalid, mem_req drops immediately (async).

Test Plan:
- Cold miss: reset, cpu_req=1, addr 0x100, mem_ack=1 every cycle, mem_data = addr.
  - Required: mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - cpu_ready=1 with cpu_data=0x100 at cycle 6; miss_count=1.
- Same-line hit: after the cold miss, addr 0x108.
  - Required: cpu_ready=1, cpu_data=0x108 in the same cycle, no mem_req, hit_count increments.
- Conflict eviction (64 lines x 4 words): fetch 0x100, then 0x500 (same index 0x10), then 0x100.
  - Required: three misses, miss_count=3, each refill fetching the correct base.
- Stalled memory: miss at 0x200 with mem_ack low for 5 cycles per beat.
  - Required: mem_addr holds each beat value throughout the stall.
  - cpu_ready only after the 4th ack; miss penalty = 1 + 4*6 cycles.
- Flush:
  - Hit on 0x100, assert flush 1 cycle, refetch 0x100: miss.
  - flush asserted during beat 2 of a refill: the line is invalid afterwards and the next fetch misses.
- Reset mid-refill: drop reset after beat 1 of 0x300.
  - Required: mem_req=0 immediately, counters=0.
  - After release, 0x300 misses and performs a full 4-beat refill.

Source files
------------

// File: rtl/icache_dm_refill.sv
// ----------------------------------------------------------------------------
// icache_dm_refill
//   Direct-mapped instruction cache with multi-word lines. Hits are answered
//   combinationally in the cycle of the request. A miss triggers a blocking,
//   handshaked burst refill of the whole line, after which the retried fetch
//   hits. Includes a whole-cache flush and saturating hit/miss counters.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cpu_req      fetch request valid
//   i_cpu_addr     fetch byte address (bits [1:0] ignored)
//   o_cpu_data     fetched word, 0 when o_cpu_ready is low
//   o_cpu_ready    o_cpu_data valid this cycle (hit)
//   i_flush        invalidate all lines
//   o_mem_req      refill beat request
//   o_mem_addr     word-aligned refill beat address
//   i_mem_ack      memory returns i_mem_data for the current beat
//   i_mem_data     refill data
//   o_hit_count    saturating hit counter
//   o_miss_count   saturating miss counter
// ----------------------------------------------------------------------------
module icache_dm_refill #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic [DATA_W-1:0] o_cpu_data,
    output logic              o_cpu_ready,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic [CNT_W-1:0]  o_miss_count
);

    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned IDX_LSB = 2 + OFF_W;
    localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

    // Clears word-select and byte-offset bits to form a line base address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE * 4 - 1);

    typedef enum logic {
        StIdle,
        StRefill
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [OFF_W-1:0]        r_beat;
    logic [ADDR_W-1:0]       r_base;
    logic [NUM_LINES-1:0]    r_valid;
    logic                    r_pend_flush;
    logic [CNT_W-1:0]        r_hit_cnt;
    logic [CNT_W-1:0]        r_miss_cnt;

    // Storage arrays carry no reset; valid bits alone qualify their contents.
    logic [TAG_W-1:0]        r_tag  [NUM_LINES];
    logic [DATA_W-1:0]       r_data [NUM_LINES*WORDS_PER_LINE];

    logic [OFF_W-1:0]        w_word;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_fill_idx;
    logic [TAG_W-1:0]        w_fill_tag;
    logic                    w_hit;
    logic                    w_last;
    logic                    w_flush_idle;
    logic                    w_start;
    logic                    w_fill_done;
    logic                    w_unused;

    assign w_word     = i_cpu_addr[IDX_LSB-1:2];
    assign w_idx      = i_cpu_addr[TAG_LSB-1:IDX_LSB];
    assign w_tag      = i_cpu_addr[ADDR_W-1:TAG_LSB];
    assign w_fill_idx = r_base[TAG_LSB-1:IDX_LSB];
    assign w_fill_tag = r_base[ADDR_W-1:TAG_LSB];
    assign w_unused   = ^i_cpu_addr[1:0];

    assign w_hit  = i_cpu_req && (r_state == StIdle) && r_valid[w_idx]
                    && (r_tag[w_idx] == w_tag);
    assign w_last = (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    // A flush deferred from a refill is applied in the first idle cycle and,
    // like a live flush, blocks a new miss from starting in that cycle.
    assign w_flush_idle = i_flush || r_pend_flush;

    assign o_hit_count  = r_hit_cnt;
    assign o_miss_count = r_miss_cnt;

    // Next-state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill_done = 1'b0;
        o_cpu_ready = 1'b0;
        o_cpu_data  = '0;
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        unique case (r_state)
            StIdle: begin
                o_cpu_ready = w_hit;
                if (w_hit) begin
                    o_cpu_data = r_data[{w_idx, w_word}];
                end
                if (i_cpu_req && !w_hit && !w_flush_idle) begin
                    w_start     = 1'b1;
                    w_state_nxt = StRefill;
                end
            end
            StRefill: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_base | ADDR_W'({r_beat, 2'b00});
                if (i_mem_ack && w_last) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Control state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_beat       <= '0;
            r_base       <= '0;
            r_valid      <= '0;
            r_pend_flush <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start) begin
                r_base <= i_cpu_addr & LINE_MASK;
                r_beat <= '0;
            end else if (r_state == StRefill && i_mem_ack) begin
                r_beat <= r_beat + 1'b1;  // wraps to 0 after the last beat
            end

            if (r_state == StIdle) begin
                if (w_flush_idle) begin
                    r_valid <= '0;
                end
                r_pend_flush <= 1'b0;
            end else begin
                if (w_fill_done) begin
                    r_valid[w_fill_idx] <= 1'b1;
                end
                r_pend_flush <= r_pend_flush | i_flush;
            end

            if (o_cpu_ready && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_start && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Tag and data arrays
    always_ff @(posedge i_clk) begin
        if (r_state == StRefill && i_mem_ack) begin
            r_data[{w_fill_idx, r_beat}] <= i_mem_data;
        end
        if (w_fill_done) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm_refill.sv
// ----------------------------------------------------------------------------
// tb_icache_dm_refill
//   Directed stimulus with a line-level reference model of the cache that is
//   compared against the DUT on every falling edge, plus hand-computed
//   literal expectations for each scenario.
// ----------------------------------------------------------------------------
module tb_icache_dm_refill;

    localparam int NL  = 64;
    localparam int WPL = 4;
    localparam int CW  = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LB  = 4 * WPL;  // bytes per line

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic [31:0]   cpu_addr = 32'h0;
    logic [31:0]   cpu_data;
    logic          cpu_ready;
    logic          flush = 1'b0;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    icache_dm_refill #(
        .ADDR_W(32), .DATA_W(32), .NUM_LINES(NL), .WORDS_PER_LINE(WPL), .CNT_W(CW)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_req   (cpu_req),
        .i_cpu_addr  (cpu_addr),
        .o_cpu_data  (cpu_data),
        .o_cpu_ready (cpu_ready),
        .i_flush     (flush),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_data  (mem_data),
        .o_hit_count (hit_count),
        .o_miss_count(miss_count)
    );

    // Memory: each word holds its own address; ack after `stall` wait cycles.
    int stall = 0;
    int wait_cnt;
    assign mem_data = mem_addr;
    assign mem_ack  = mem_req && (wait_cnt >= stall);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ---------------- reference model (line granularity) ----------------
    logic        m_busy;
    logic [31:0] m_base;
    int          m_beat;
    logic        m_pend;
    int          m_hits, m_misses;
    logic        m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL][WPL];

    function automatic int a_idx(input logic [31:0] a);  return int'((a / LB) % NL);  endfunction
    function automatic int a_word(input logic [31:0] a); return int'((a / 4) % WPL);  endfunction
    function automatic logic [31:0] a_tag(input logic [31:0] a); return a / (LB * NL); endfunction

    function automatic bit m_hit_now();
        return !m_busy && cpu_req && m_valid[a_idx(cpu_addr)] === 1'b1
               && m_tag[a_idx(cpu_addr)] == a_tag(cpu_addr);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_beat <= 0; m_pend <= 1'b0; m_hits <= 0; m_misses <= 0;
            for (int i = 0; i < NL; i++) m_valid[i] <= 1'b0;
        end else if (!m_busy) begin
            if (m_hit_now() && m_hits < CMAX) m_hits <= m_hits + 1;
            if (flush || m_pend) begin
                for (int i = 0; i < NL; i++) m_valid[i] <= 1'b0;
                m_pend <= 1'b0;
            end else if (cpu_req && !m_hit_now()) begin
                m_busy <= 1'b1;
                m_base <= cpu_addr - (cpu_addr % LB);
                m_beat <= 0;
                if (m_misses < CMAX) m_misses <= m_misses + 1;
            end
        end else begin
            if (flush) m_pend <= 1'b1;
            if (mem_ack) begin
                m_data[a_idx(m_base)][m_beat] <= mem_data;
                if (m_beat == WPL - 1) begin
                    m_valid[a_idx(m_base)] <= 1'b1;
                    m_tag[a_idx(m_base)]   <= a_tag(m_base);
                    m_busy <= 1'b0;
                    m_beat <= 0;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, m_hit_now()});
            chk("cpu_data", cpu_data,
                m_hit_now() ? m_data[a_idx(cpu_addr)][a_word(cpu_addr)] : 32'h0);
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
            if (m_busy) chk("mem_addr", mem_addr, m_base + 32'(4 * m_beat));
            chk("hit_count", 32'(hit_count), 32'(m_hits));
            chk("miss_count", 32'(miss_count), 32'(m_misses));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] beats[$];

    task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] d);
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_req  = 1'b1;
        beats.delete();
        cyc = 0;
        d   = 32'h0;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                d = cpu_data;
                break;
            end
            if (mem_req) beats.push_back(mem_addr);
            cyc++;
            if (cyc > 300) begin
                timeout("fetch");
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_beat(input logic [31:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == a) && n < 50);
        if (n >= 50) timeout("wait_beat");
    endtask

    initial begin
        int          cyc;
        logic [31:0] d;
        int          n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        chk("rst_cpu_data", cpu_data, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_hits", 32'(hit_count), 32'h0);
        chk("rst_misses", 32'(miss_count), 32'h0);
        rst_n = 1'b1;

        // Cold miss
        fetch(32'h100, cyc, d);
        chk("cold_penalty", 32'(cyc), 32'd5);
        chk("cold_data", d, 32'h100);
        chk("cold_nbeats", 32'(beats.size()), 32'd4);
        if (beats.size() == 4) begin
            chk("cold_beat0", beats[0], 32'h100);
            chk("cold_beat1", beats[1], 32'h104);
            chk("cold_beat2", beats[2], 32'h108);
            chk("cold_beat3", beats[3], 32'h10C);
        end
        chk("cold_misses", 32'(miss_count), 32'd1);
        chk("cold_hits", 32'(hit_count), 32'd1);

        // Same-line hit
        fetch(32'h108, cyc, d);
        chk("hit_latency", 32'(cyc), 32'd0);
        chk("hit_data", d, 32'h108);
        chk("hit_no_mem", 32'(beats.size()), 32'd0);
        chk("hit_hits", 32'(hit_count), 32'd2);

        // Conflict eviction on index 0x10
        fetch(32'h500, cyc, d);
        chk("evict_penalty", 32'(cyc), 32'd5);
        chk("evict_data", d, 32'h500);
        if (beats.size() == 4) chk("evict_beat3", beats[3], 32'h50C);
        else                   chk("evict_nbeats", 32'(beats.size()), 32'd4);
        fetch(32'h100, cyc, d);
        chk("refetch_penalty", 32'(cyc), 32'd5);
        chk("refetch_beat0", beats.size() > 0 ? beats[0] : 32'hDEAD, 32'h100);
        chk("evict_misses", 32'(miss_count), 32'd3);

        // Stalled memory
        stall = 5;
        fetch(32'h200, cyc, d);
        stall = 0;
        chk("stall_penalty", 32'(cyc), 32'd25);
        chk("stall_data", d, 32'h200);
        chk("stall_nbeats", 32'(beats.size()), 32'd24);
        if (beats.size() == 24) begin
            chk("stall_hold0", beats[5], 32'h200);
            chk("stall_beat1", beats[6], 32'h204);
            chk("stall_hold3", beats[23], 32'h20C);
        end

        // Flush in idle
        fetch(32'h100, cyc, d);
        chk("preflush_hit", 32'(cyc), 32'd0);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        fetch(32'h100, cyc, d);
        chk("postflush_miss", 32'(cyc), 32'd5);
        chk("flush_misses", 32'(miss_count), 32'd5);
        chk("flush_hits", 32'(hit_count), 32'd7);

        // Flush during beat 2 of a refill
        @(posedge clk); #1;
        cpu_addr = 32'h600;
        cpu_req  = 1'b1;
        wait_beat(32'h608);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 20);
        if (n >= 20) timeout("pend_flush_ready");
        chk("pend_flush_data", cpu_data, 32'h600);
        @(posedge clk); #1 cpu_req = 1'b0;
        fetch(32'h600, cyc, d);
        chk("pend_flush_miss", 32'(cyc), 32'd5);
        chk("pend_flush_misses", 32'(miss_count), 32'd7);

        // Reset during refill
        @(posedge clk); #1;
        cpu_addr = 32'h300;
        cpu_req  = 1'b1;
        wait_beat(32'h308);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rstmid_hits", 32'(hit_count), 32'h0);
        chk("rstmid_misses", 32'(miss_count), 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h300, cyc, d);
        chk("rstmid_penalty", 32'(cyc), 32'd5);
        chk("rstmid_nbeats", 32'(beats.size()), 32'd4);
        if (beats.size() == 4) begin
            chk("rstmid_beat0", beats[0], 32'h300);
            chk("rstmid_beat3", beats[3], 32'h30C);
        end
        chk("rstmid_data", d, 32'h300);
        fetch(32'h100, cyc, d);
        chk("rstmid_invalid", 32'(cyc), 32'd5);

        // Hit counter saturation (2 hits so far, then 40 more)
        @(posedge clk); #1;
        cpu_addr = 32'h104;
        cpu_req  = 1'b1;
        repeat (40) @(posedge clk);
        #1 cpu_req = 1'b0;
        chk("sat_hits", 32'(hit_count), 32'(CMAX));
        chk("sat_misses", 32'(miss_count), 32'd2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
